mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (read/write).

---
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the fetch stage (read-only)
// and the memory stage (read/write). Only one transaction is outstanding at a
// time. Each requester is stalled until its own access completes.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   defined   -> after MAX_DATA_WINS consecutive data grants made while fetch
//                was waiting, the next contested arbitration goes to fetch.
//   undefined -> strict data-over-fetch priority.
//
// Handshake semantics (both requester ports):
//   A requester raises *_req (level) with stable address/data and holds it
//   until the matching *_valid pulse. *_valid is a single-cycle completion
//   pulse; *_rdata is meaningful only in that cycle and is 0 otherwise.
//   The memory side accepts mem_req when mem_gnt=1 in the same cycle, and
//   answers later with a one-cycle mem_rvalid carrying mem_rdata.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   if_req/if_addr                fetch request, address
//   if_rdata/if_valid             fetch data, completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be                data request (load/store)
//   dm_rdata/dm_valid             load data, completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be              request to memory
//   mem_gnt/mem_rvalid/mem_rdata  memory accept, response, read data
//   stall_if/stall_mem            hazard-unit stalls
//   err                           sticky timeout flag
//   dbg_state                     current FSM state (0 IDLE, 1 WAIT_GNT,
//                                 2 WAIT_RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_DATA_WINS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [DATA_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_valid,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [DATA_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_valid,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    stall_if,
  output logic                    stall_mem,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  owner_t                  owner;
  logic [CNT_W-1:0]        cnt;
  logic                    lat_we;
  logic [DATA_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH/8-1:0] lat_be;
  logic                    err_q;

  logic timeout_hit;
  logic resp_hit;
  logic done;
  logic grant_dm;
  logic grant_if;

  // A real response in the last allowed cycle counts as a normal completion.
  assign resp_hit    = (state == WAIT_RESP) && mem_rvalid;
  assign timeout_hit = (state != IDLE) && (cnt == CNT_LAST) && !resp_hit;
  assign done        = resp_hit || timeout_hit;

`ifdef ARB_STARVE_GUARD_EN
  // Consecutive data grants made while fetch was pending.
  logic [2:0] wins;
  logic       guard_hit;

  assign guard_hit = dm_req && if_req && (wins == 3'(MAX_DATA_WINS));
  assign grant_dm  = dm_req && !guard_hit;
  assign grant_if  = if_req && !grant_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wins <= 3'd0;
    end else if (!if_req) begin
      wins <= 3'd0;
    end else if (state == IDLE) begin
      if (grant_if) begin
        wins <= 3'd0;
      end else if (grant_dm && (wins != 3'd7)) begin
        wins <= wins + 3'd1;
      end
    end
  end
`else
  assign grant_dm = dm_req;
  assign grant_if = if_req && !dm_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (grant_dm) begin
            owner     <= OWN_DM;
            lat_we    <= dm_we;
            lat_addr  <= dm_addr;
            lat_wdata <= dm_wdata;
            lat_be    <= dm_be;
            state     <= WAIT_GNT;
          end else if (grant_if) begin
            // Fetches are always full-word reads.
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_addr  <= if_addr;
            lat_wdata <= '0;
            lat_be    <= '1;
            state     <= WAIT_GNT;
          end else begin
            owner <= OWN_NONE;
          end
        end
        WAIT_GNT: begin
          // Abort takes precedence over a grant in the same cycle; any
          // response that follows lands in IDLE and is dropped.
          if (timeout_hit) begin
            err_q <= 1'b1;
            owner <= OWN_NONE;
            cnt   <= '0;
            state <= IDLE;
          end else if (mem_gnt) begin
            cnt   <= '0;
            state <= WAIT_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RESP: begin
          if (resp_hit) begin
            owner <= OWN_NONE;
            cnt   <= '0;
            state <= IDLE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            owner <= OWN_NONE;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          owner <= OWN_NONE;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_req   = (state == WAIT_GNT);
    mem_we    = mem_req && lat_we;
    mem_addr  = mem_req ? lat_addr  : '0;
    mem_wdata = mem_req ? lat_wdata : '0;
    mem_be    = mem_req ? lat_be    : '0;

    if_valid  = done && (owner == OWN_IF);
    dm_valid  = done && (owner == OWN_DM);
    // Aborted transactions complete with zero data.
    if_rdata  = (if_valid && resp_hit) ? mem_rdata : '0;
    dm_rdata  = (dm_valid && resp_hit) ? mem_rdata : '0;

    stall_if  = if_req && !if_valid;
    stall_mem = dm_req && !dm_valid;
    err       = err_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change on the falling edge and
// outputs are sampled on the falling edge. A small memory responder can run
// in automatic mode (grant immediately, respond one cycle later with data
// derived from the address) or be driven by hand for exact-timing cases.
// Completion order and data are tracked with expected queues.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  logic [1:0]  dbg_state;

  // Memory responder controls
  logic        auto_mem;
  logic        gnt_man;
  logic        rv_man;
  logic [31:0] rd_man;
  logic        rv_auto;
  logic [31:0] rd_auto;

  // Scoreboard
  logic [31:0] exp_q[$];
  logic        own_q[$];   // 1 = data port, 0 = fetch port
  int          n_tests;
  int          n_fail;
  int          dm_left;

  mem_port_arbiter #(
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(64),
    .MAX_DATA_WINS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h0000_0093;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  assign mem_gnt    = auto_mem ? mem_req : gnt_man;
  assign mem_rvalid = auto_mem ? rv_auto : rv_man;
  assign mem_rdata  = auto_mem ? (rv_auto ? rd_auto : 32'hDEAD_0000) : rd_man;

  always @(posedge clk) begin
    rv_auto <= auto_mem && mem_req && mem_gnt;
    rd_auto <= rd_fn(mem_addr);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic own, input logic [31:0] data);
    own_q.push_back(own);
    exp_q.push_back(data);
  endtask

  // Sample completions at the current falling edge; requesters drop their
  // request once they see their completion.
  task automatic observe();
    logic [31:0] e;
    logic        o;
    if (if_valid || dm_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {30'd0, dm_valid, if_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        o = own_q.pop_front();
        check("owner", {31'd0, dm_valid}, {31'd0, o});
        check("rdata", dm_valid ? dm_rdata : if_rdata, e);
      end
      if (if_valid) if_req = 1'b0;
      if (dm_valid) begin
        dm_left--;
        if (dm_left <= 0) dm_req = 1'b0;
      end
    end else begin
      check("if_rdata_idle", if_rdata, 32'd0);
      check("dm_rdata_idle", dm_rdata, 32'd0);
    end
  endtask

  task automatic drive_idle();
    if_req   = 1'b0;
    if_addr  = 32'd0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'd0;
    dm_wdata = 32'd0;
    dm_be    = 4'd0;
    gnt_man  = 1'b0;
    rv_man   = 1'b0;
    rd_man   = 32'd0;
    auto_mem = 1'b0;
    dm_left  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    exp_q.delete();
    own_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_issue;
    int req_cycles;
    logic seen;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    drive_idle();

    // 1: reset holds everything at zero even with a pending fetch
    if_req  = 1'b1;
    if_addr = 32'h0000_1000;
    repeat (2) @(negedge clk);
    check("rst_mem_req",  {31'd0, mem_req},  32'd0);
    check("rst_mem_addr", mem_addr,          32'd0);
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    check("rst_if_rdata", if_rdata,          32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_state",    {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_mem_req",  {31'd0, mem_req}, 32'd1);
    check("post_rst_mem_addr", mem_addr,         32'h0000_1000);

    // 2: single fetch with exact timing
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'hBFC0_0000;
    @(negedge clk);                         // N+1
    check("f_mem_req",  {31'd0, mem_req},  32'd1);
    check("f_mem_addr", mem_addr,          32'hBFC0_0000);
    check("f_mem_we",   {31'd0, mem_we},   32'd0);
    check("f_mem_be",   {28'd0, mem_be},   32'hF);
    check("f_stall_if", {31'd0, stall_if}, 32'd1);
    gnt_man = 1'b1;
    @(negedge clk);                         // N+2
    check("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("f_if_valid_pre", {31'd0, if_valid}, 32'd0);
    gnt_man = 1'b0;
    rv_man  = 1'b1;
    rd_man  = 32'h0000_0093;
    #1;
    check("f_if_valid",  {31'd0, if_valid}, 32'd1);
    check("f_if_rdata",  if_rdata,          32'h0000_0093);
    check("f_stall_off", {31'd0, stall_if}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);                         // N+3, rvalid still high: stray
    check("f_idle_state",   {30'd0, dbg_state}, 32'd0);
    check("f_stray_valid",  {31'd0, if_valid},  32'd0);
    check("f_stray_rdata",  if_rdata,           32'd0);
    check("f_stall_if_n3",  {31'd0, stall_if},  32'd0);
    rv_man = 1'b0;

    // 3: contention, store goes first
    do_reset();
    auto_mem = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h0000_2000;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF;
    dm_be    = 4'hF;
    dm_left  = 1;
    push_exp(1'b1, rd_fn(32'h0000_0100));
    push_exp(1'b0, rd_fn(32'h0000_2000));
    n_issue = 0;
    for (int c = 0; c < 100 && (if_req || dm_req); c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (n_issue == 0) begin
          check("c_st_we",    {31'd0, mem_we}, 32'd1);
          check("c_st_addr",  mem_addr,        32'h0000_0100);
          check("c_st_wdata", mem_wdata,       32'hDEAD_BEEF);
          check("c_st_be",    {28'd0, mem_be}, 32'hF);
        end else if (n_issue == 1) begin
          check("c_f_we",    {31'd0, mem_we}, 32'd0);
          check("c_f_addr",  mem_addr,        32'h0000_2000);
          check("c_f_be",    {28'd0, mem_be}, 32'hF);
        end
        n_issue++;
      end
      if (if_req && !if_valid) check("c_stall_if", {31'd0, stall_if}, 32'd1);
      observe();
    end
    check("c_done",     {30'd0, dm_req, if_req}, 32'd0);
    check("c_issues",   n_issue,                 32'd2);
    check("c_q_empty",  exp_q.size(),            32'd0);

    // 4: timeout on a load that is never granted
    do_reset();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0200;
    dm_be   = 4'hF;
    req_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (if_valid) check("t_if_valid", 32'd1, 32'd0);
      if (dm_valid) begin
        seen = 1'b1;
        check("t_dm_rdata", dm_rdata,     32'd0);
        check("t_err_pre",  {31'd0, err}, 32'd0);
        dm_req = 1'b0;
      end
    end
    check("t_seen",       {31'd0, seen}, 32'd1);
    check("t_req_cycles", req_cycles,    32'd64);
    @(negedge clk);
    check("t_err",     {31'd0, err},       32'd1);
    check("t_mem_req", {31'd0, mem_req},   32'd0);
    check("t_state",   {30'd0, dbg_state}, 32'd0);
    rv_man = 1'b1;
    rd_man = 32'hCAFE_F00D;
    #1;
    check("t_late_valid", {30'd0, dm_valid, if_valid}, 32'd0);
    check("t_late_rdata", dm_rdata, 32'd0);
    @(negedge clk);
    rv_man = 1'b0;
    check("t_err_sticky", {31'd0, err}, 32'd1);

    // 5: reset in the middle of WAIT_RESP
    do_reset();
    check("m_err_clear", {31'd0, err}, 32'd0);
    dm_req  = 1'b1;
    dm_addr = 32'h0000_0300;
    dm_be   = 4'hF;
    @(negedge clk);
    check("m_wait_gnt", {30'd0, dbg_state}, 32'd1);
    gnt_man = 1'b1;
    @(negedge clk);
    check("m_wait_resp", {30'd0, dbg_state}, 32'd2);
    gnt_man = 1'b0;
    rst     = 1'b0;
    dm_req  = 1'b0;
    #1;
    check("m_rst_state",   {30'd0, dbg_state}, 32'd0);
    check("m_rst_mem_req", {31'd0, mem_req},   32'd0);
    @(negedge clk);
    rst    = 1'b1;
    rv_man = 1'b1;
    rd_man = 32'h0000_0055;
    #1;
    check("m_no_valid", {30'd0, dm_valid, if_valid}, 32'd0);
    @(negedge clk);
    check("m_no_valid2", {30'd0, dm_valid, if_valid}, 32'd0);
    check("m_idle",      {30'd0, dbg_state},         32'd0);
    rv_man = 1'b0;

    // 6: back-to-back loads with fetch waiting
    do_reset();
    auto_mem = 1'b1;
    if_req   = 1'b1;
    if_addr  = 32'h0000_3000;
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 32'h0000_0400;
    dm_be    = 4'hF;
    dm_left  = 6;
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) push_exp(1'b1, rd_fn(32'h0000_0400));
    push_exp(1'b0, rd_fn(32'h0000_3000));
    for (int i = 0; i < 2; i++) push_exp(1'b1, rd_fn(32'h0000_0400));
`else
    for (int i = 0; i < 6; i++) push_exp(1'b1, rd_fn(32'h0000_0400));
    push_exp(1'b0, rd_fn(32'h0000_3000));
`endif
    for (int c = 0; c < 300 && (if_req || dm_req); c++) begin
      @(negedge clk);
      observe();
    end
    check("g_done",    {30'd0, dm_req, if_req}, 32'd0);
    check("g_q_empty", exp_q.size(),            32'd0);
    check("g_err",     {31'd0, err},            32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
